cpu_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the master CPU.
- Fetches 32-bit instructions from RAM at the PC and splits them into fields:
  - Cond[31:28], OpCode[27:24], S[23], dest[22:19], src2[18:15], src1[14:11], shift[10:6], imm[18:3].
- Sequences the register bank, ALU and RAM through one shared RAM port.
- Owns the PC, instruction register, flag register and halt state.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_sequencer_cond.sv | 39 +++
 rtl/cpu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU sequencer and its condition checker.
package cpu_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Opcodes the sequencer treats specially; all others go through the ALU.
  localparam logic [3:0] OP_B    = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_LDR  = 4'hD;
  localparam logic [3:0] OP_STR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Condition codes.
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4;
  localparam logic [3:0] CC_PL = 4'h5;
  localparam logic [3:0] CC_VS = 4'h6;
  localparam logic [3:0] CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8;
  localparam logic [3:0] CC_LS = 4'h9;
  localparam logic [3:0] CC_GE = 4'hA;
  localparam logic [3:0] CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC;
  localparam logic [3:0] CC_LE = 4'hD;
  localparam logic [3:0] CC_AL = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Flag bit positions within {N,Z,C,V}.
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/cpu_sequencer_cond.sv
// Condition evaluation: decides whether an instruction executes given the flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;
  assign w_n = flags[FLG_N];
  assign w_z = flags[FLG_Z];
  assign w_c = flags[FLG_C];
  assign w_v = flags[FLG_V];

  // Decode the 16 condition codes against the current flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = w_z;
      CC_NE: pass = ~w_z;
      CC_CS: pass = w_c;
      CC_CC: pass = ~w_c;
      CC_MI: pass = w_n;
      CC_PL: pass = ~w_n;
      CC_VS: pass = w_v;
      CC_VC: pass = ~w_v;
      CC_HI: pass = w_c & ~w_z;
      CC_LS: pass = ~w_c | w_z;
      CC_GE: pass = (w_n == w_v);
      CC_LT: pass = (w_n != w_v);
      CC_GT: pass = ~w_z & (w_n == w_v);
      CC_LE: pass = w_z | (w_n != w_v);
      CC_AL: pass = 1'b1;
      default: pass = 1'b0;  // NV
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute controller. Owns PC, IR, flags and halt
// state, and sequences the register bank, ALU and a single shared RAM port.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int PC_W    = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  output logic            ram_en,
  output logic            ram_rw,
  output logic [15:0]     ram_addr,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata,
  output logic [3:0]      rf_src1,
  output logic [3:0]      rf_src2,
  input  logic [31:0]     rf_rdata1,
  input  logic [31:0]     rf_rdata2,
  output logic            rf_wen,
  output logic [3:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [3:0]      alu_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [4:0]      alu_shift,
  output logic [15:0]     alu_imm,
  output logic            alu_s,
  input  logic [31:0]     alu_result,
  input  logic [3:0]      alu_flag,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            halted
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [3:0]      r_flags;
  logic [31:0]     r_ir;
  logic [31:0]     r_a;
  logic [31:0]     r_b;
  logic [31:0]     r_r;
  logic [CNT_W-1:0] r_cnt;
  // Low for the first cycle after reset so the bus stays idle that cycle.
  logic            r_live;

  // IR fields.
  logic [3:0]  w_cond, w_op, w_dest, w_src2, w_src1;
  logic        w_s;
  logic [4:0]  w_shift;
  logic [15:0] w_imm;
  assign w_cond  = r_ir[31:28];
  assign w_op    = r_ir[27:24];
  assign w_s     = r_ir[23];
  assign w_dest  = r_ir[22:19];
  assign w_src2  = r_ir[18:15];
  assign w_src1  = r_ir[14:11];
  assign w_shift = r_ir[10:6];
  assign w_imm   = r_ir[18:3];

  logic w_pass, w_last, w_fetch, w_mem, w_store;
  assign w_last  = (r_cnt == CNT_W'(RAM_LAT - 1));
  assign w_fetch = (r_state == ST_FETCH) && r_live;
  assign w_mem   = (r_state == ST_MEM);
  assign w_store = w_mem && (w_op == OP_STR);

  cond_check u_cond (
    .cond  (w_cond),
    .flags (r_flags),
    .pass  (w_pass)
  );

  // Bus and datapath outputs are decoded straight from state and latches.
  always_comb begin
    ram_en    = w_fetch | w_mem;
    ram_rw    = ~w_store;
    ram_addr  = w_fetch ? 16'(r_pc) : (w_mem ? r_a[15:0] : 16'd0);
    ram_wdata = w_store ? r_b : 32'd0;
    rf_src1   = w_src1;
    rf_src2   = w_src2;
    rf_wen    = (r_state == ST_WB);
    rf_waddr  = w_dest;
    rf_wdata  = r_r;
    alu_op    = w_op;
    alu_a     = r_a;
    alu_b     = r_b;
    alu_shift = w_shift;
    alu_imm   = w_imm;
    alu_s     = w_s;
    pc        = r_pc;
    flags     = r_flags;
    halted    = (r_state == ST_HALT);
  end

  // Instruction sequencing state machine.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_flags <= '0;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_FETCH: begin
          if (r_live) begin
            if (w_last) begin
              r_ir    <= ram_rdata;
              r_cnt   <= '0;
              r_state <= ST_DECODE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DECODE: begin
          r_a <= rf_rdata1;
          r_b <= rf_rdata2;
          if (!w_pass) begin
            r_pc    <= r_pc + PC_W'(1);
            r_state <= ST_FETCH;
          end else begin
            case (w_op)
              OP_HALT: r_state <= ST_HALT;
              OP_B: begin
                r_pc    <= w_imm[PC_W-1:0];
                r_state <= ST_FETCH;
              end
              OP_LDR, OP_STR: r_state <= ST_MEM;
              default: r_state <= ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          r_r <= alu_result;
          if (w_s) r_flags <= alu_flag;
          if (w_op == OP_CMP) begin
            r_pc    <= r_pc + PC_W'(1);
            r_state <= ST_FETCH;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_op == OP_STR) begin
              r_pc    <= r_pc + PC_W'(1);
              r_state <= ST_FETCH;
            end else begin
              r_r     <= ram_rdata;
              r_state <= ST_WB;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          r_pc    <= r_pc + PC_W'(1);
          r_state <= ST_FETCH;
        end
        ST_HALT: begin
          if (start) begin
            r_pc    <= r_pc + PC_W'(1);
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: RAM, register bank and ALU models;
// every bus event the DUT produces is matched against an expected queue.
module tb_cpu_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        ram_en, ram_rw;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  rf_src1, rf_src2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_wen;
  logic [3:0]  alu_op, alu_flag;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shift;
  logic [15:0] alu_imm;
  logic        alu_s;
  logic [7:0]  pc;
  logic [3:0]  flags;
  logic        halted;

  cpu_sequencer #(.RAM_LAT(1), .PC_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .start(start),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rf_src1(rf_src1), .rf_src2(rf_src2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_shift(alu_shift), .alu_imm(alu_imm), .alu_s(alu_s),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .pc(pc), .flags(flags), .halted(halted)
  );

  always #5 Clk = ~Clk;

  // Environment models: RAM and register bank are loaded only by the bench.
  logic [31:0] mem [0:255];
  logic [31:0] rf  [0:15];
  assign ram_rdata = mem[ram_addr[7:0]];
  assign rf_rdata1 = rf[rf_src1];
  assign rf_rdata2 = rf[rf_src2];

  // ALU model: CMP subtracts, everything else adds.
  logic [32:0] alu_sum;
  logic [31:0] alu_bb;
  always_comb begin
    alu_bb     = (alu_op == 4'hB) ? ~alu_b : alu_b;
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_bb} + ((alu_op == 4'hB) ? 33'd1 : 33'd0);
    alu_result = alu_sum[31:0];
    alu_flag   = {alu_sum[31], alu_sum[31:0] == 32'd0, alu_sum[32],
                  (alu_a[31] == alu_bb[31]) && (alu_sum[31] != alu_a[31])};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of bus events.
  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_RF = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;
  ev_t sb[$];

  task automatic exp_rd(input logic [15:0] a);
    sb.push_back('{kind: K_RD, addr: a, data: 32'd0});
  endtask
  task automatic exp_wr(input logic [15:0] a, input logic [31:0] d);
    sb.push_back('{kind: K_WR, addr: a, data: d});
  endtask
  task automatic exp_rf(input logic [3:0] a, input logic [31:0] d);
    sb.push_back('{kind: K_RF, addr: {12'd0, a}, data: d});
  endtask

  task automatic observe(input ev_t e);
    ev_t x;
    if (sb.size() == 0) chk("sb_extra_event", 64'(sb.size()), 64'd1);
    else begin
      x = sb.pop_front();
      chk("sb_event", 64'(e), 64'(x));
    end
  endtask

  // Monitor samples the bus mid-cycle.
  always @(negedge Clk) begin
    if (ram_en)
      observe('{kind: ram_rw ? K_RD : K_WR, addr: ram_addr,
                data: ram_rw ? 32'd0 : ram_wdata});
    if (rf_wen)
      observe('{kind: K_RF, addr: {12'd0, rf_waddr}, data: rf_wdata});
  end

  localparam logic [31:0] HALT_W = 32'hEF00_0000;

  function automatic logic [31:0] enc(input logic [3:0] c, input logic [3:0] op,
                                      input logic s, input logic [3:0] d,
                                      input logic [3:0] s2, input logic [3:0] s1);
    enc = {c, op, s, d, s2, s1, 11'd0};
  endfunction
  function automatic logic [31:0] encb(input logic [3:0] c, input logic [15:0] imm);
    encb = {c, 4'hA, 5'd0, imm, 3'd0};
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic init_env();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
  endtask

  // Leaves the bench at cycle 0: the first cycle with the fetch on the bus.
  task automatic reset_dut();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin tick(); n++; end
    chk("halt_wait", 64'(halted), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bus_cnt;
    int pc_moves;

    // ADD r3 = r1 + r2, S=1.
    init_env();
    rf[1] = 32'd5; rf[2] = 32'd7;
    mem[0] = enc(4'hE, 4'h0, 1'b1, 4'd3, 4'd2, 4'd1);
    Reset = 1'b1;
    tick();
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_rw", 64'(ram_rw), 64'd1);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    exp_rd(16'h0); exp_rf(4'd3, 32'd12); exp_rd(16'h1);
    tick(); Reset = 1'b0; tick();
    chk("add_c0_en", 64'(ram_en), 64'd1);
    chk("add_c0_addr", 64'(ram_addr), 64'd0);
    tick(); tick(); tick();
    chk("add_c3_wen", 64'(rf_wen), 64'd1);
    chk("add_c3_waddr", 64'(rf_waddr), 64'd3);
    chk("add_c3_wdata", 64'(rf_wdata), 64'd12);
    tick();
    chk("add_c4_flags", 64'(flags), 64'h0);
    chk("add_c4_pc", 64'(pc), 64'd1);
    wait_halt(20);
    chk("add_sb_empty", 64'(sb.size()), 64'd0);

    // CMP r1,r1 then BNE 0x20 (not taken), then BEQ 0x20 (taken).
    for (int t = 0; t < 2; t++) begin
      init_env();
      rf[1] = 32'd9;
      mem[0] = enc(4'hE, 4'hB, 1'b1, 4'd0, 4'd1, 4'd1);
      mem[1] = encb((t == 0) ? 4'h1 : 4'h0, 16'h0020);
      exp_rd(16'h0); exp_rd(16'h1); exp_rd((t == 0) ? 16'h2 : 16'h20);
      reset_dut();
      tick(); tick(); tick();
      chk("cmp_c3_flags", 64'(flags), 64'b0110);
      chk("cmp_c3_addr", 64'(ram_addr), 64'd1);
      wait_halt(20);
      chk("br_pc", 64'(pc), (t == 0) ? 64'd2 : 64'h20);
      chk("br_sb_empty", 64'(sb.size()), 64'd0);
    end

    // LDR r4,[r1].
    init_env();
    rf[1] = 32'h40;
    mem[0] = enc(4'hE, 4'hD, 1'b0, 4'd4, 4'd0, 4'd1);
    mem[8'h40] = 32'hDEAD_BEEF;
    exp_rd(16'h0); exp_rd(16'h40); exp_rf(4'd4, 32'hDEAD_BEEF); exp_rd(16'h1);
    reset_dut();
    tick(); tick();
    chk("ldr_mem_addr", 64'(ram_addr), 64'h40);
    chk("ldr_mem_rw", 64'(ram_rw), 64'd1);
    tick();
    chk("ldr_wb_data", 64'(rf_wdata), 64'hDEAD_BEEF);
    tick();
    chk("ldr_next_addr", 64'(ram_addr), 64'd1);
    wait_halt(20);
    chk("ldr_sb_empty", 64'(sb.size()), 64'd0);

    // STR r2,[r1].
    init_env();
    rf[1] = 32'h41; rf[2] = 32'h1234;
    mem[0] = enc(4'hE, 4'hE, 1'b0, 4'd0, 4'd2, 4'd1);
    exp_rd(16'h0); exp_wr(16'h41, 32'h1234); exp_rd(16'h1);
    reset_dut();
    tick(); tick();
    chk("str_rw", 64'(ram_rw), 64'd0);
    chk("str_wdata", 64'(ram_wdata), 64'h1234);
    tick();
    chk("str_next_addr", 64'(ram_addr), 64'd1);
    wait_halt(20);
    chk("str_sb_empty", 64'(sb.size()), 64'd0);

    // HALT at pc=5, idle, then start; start outside HALT is ignored.
    init_env();
    rf[1] = 32'd5; rf[2] = 32'd7;
    mem[0] = encb(4'hE, 16'h5);
    mem[6] = enc(4'hE, 4'h0, 1'b0, 4'd3, 4'd2, 4'd1);
    exp_rd(16'h0); exp_rd(16'h5);
    reset_dut();
    wait_halt(20);
    bus_cnt = 0; pc_moves = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_en) bus_cnt++;
      if (pc != 8'd5) pc_moves++;
    end
    chk("halt_bus_idle", 64'(bus_cnt), 64'd0);
    chk("halt_pc_hold", 64'(pc_moves), 64'd0);
    exp_rd(16'h6); exp_rf(4'd3, 32'd12); exp_rd(16'h7);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_addr", 64'(ram_addr), 64'd6);
    chk("start_halted", 64'(halted), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_halt(20);
    chk("start_pc", 64'(pc), 64'd7);
    chk("halt_sb_empty", 64'(sb.size()), 64'd0);

    // PC wrap: ALU op at 0xFF falls through to 0x00.
    init_env();
    mem[0] = encb(4'hE, 16'hFE);
    mem[8'hFF] = enc(4'hE, 4'h1, 1'b0, 4'd0, 4'd0, 4'd0);
    exp_rd(16'h0); exp_rd(16'hFE);
    reset_dut();
    wait_halt(20);
    exp_rd(16'hFF); exp_rf(4'd0, 32'd0); exp_rd(16'h0); exp_rd(16'hFE);
    start = 1'b1; tick(); start = 1'b0;
    chk("wrap_pc_ff", 64'(pc), 64'hFF);
    tick(); tick(); tick(); tick();
    chk("wrap_pc_0", 64'(pc), 64'h0);
    wait_halt(20);
    chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

    // Reset asserted during the LDR memory cycle.
    init_env();
    rf[1] = 32'h40; rf[4] = 32'h55;
    mem[0] = enc(4'hE, 4'hD, 1'b0, 4'd4, 4'd0, 4'd1);
    mem[8'h40] = 32'hDEAD_BEEF;
    exp_rd(16'h0); exp_rd(16'h40);
    reset_dut();
    tick(); tick();
    chk("abort_mem_en", 64'(ram_en), 64'd1);
    Reset = 1'b1;
    tick();
    chk("abort_en", 64'(ram_en), 64'd0);
    chk("abort_pc", 64'(pc), 64'd0);
    chk("abort_wen", 64'(rf_wen), 64'd0);
    mem[0] = HALT_W;
    exp_rd(16'h0);
    Reset = 1'b0;
    wait_halt(20);
    chk("abort_end_pc", 64'(pc), 64'd0);
    chk("abort_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
